// File: rtl/bcd_convert_arbiter.sv
// rtl/bcd_convert_arbiter.sv - round-robin sharing of one binary-to-BCD converter
module bcd_convert_arbiter #(
  parameter int N_REQ   = 3,
  parameter int BIN_W   = 20,
  parameter int BCD_W   = 28,
  parameter int TIMEOUT = 40
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*BIN_W-1:0] Req_Bin,
  output logic [N_REQ-1:0]       Ack,
  output logic [BCD_W-1:0]       Res_Bcd,
  output logic                   Timeout_Err,
  output logic                   Busy,
  output logic                   Conv_Start,
  output logic [BIN_W-1:0]       Conv_Bin,
  input  logic [BCD_W-1:0]       Conv_Bcd,
  input  logic                   Conv_Done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TIM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [PTR_W-1:0]   grant_q, grant_nxt;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_nxt;
  logic [TIM_W-1:0]   timer_q, timer_nxt;
  logic [N_REQ-1:0]   ack_q, ack_nxt;
  logic [BCD_W-1:0]   res_bcd_q, res_bcd_nxt;
  logic               timeout_err_q, timeout_err_nxt;
  logic               conv_start_q, conv_start_nxt;
  logic [BIN_W-1:0]   conv_bin_q, conv_bin_nxt;
  logic               busy_q, busy_nxt;

  logic               req_any;
  logic [PTR_W-1:0]   pick;

  // Round-robin pick: first active request after the last granted channel
  always_comb begin
    req_any = 1'b0;
    pick    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!req_any && Req[(int'(rr_ptr_q) + k) % N_REQ]) begin
        req_any = 1'b1;
        pick    = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  // Next-state and next-output decode; Ack and Timeout_Err default low so they pulse
  always_comb begin
    state_nxt       = state_q;
    grant_nxt       = grant_q;
    rr_ptr_nxt      = rr_ptr_q;
    timer_nxt       = timer_q;
    ack_nxt         = '0;
    res_bcd_nxt     = res_bcd_q;
    timeout_err_nxt = 1'b0;
    conv_start_nxt  = 1'b0;
    conv_bin_nxt    = conv_bin_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_nxt      = S_START;
          grant_nxt      = pick;
          rr_ptr_nxt     = pick;
          conv_start_nxt = 1'b1;
          conv_bin_nxt   = Req_Bin[int'(pick)*BIN_W +: BIN_W];
        end
      end
      S_START: begin
        timer_nxt = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        timer_nxt = timer_q + 1'b1;
        // A completion in the same cycle as the watchdog expiry counts as success
        if (Conv_Done) begin
          res_bcd_nxt = Conv_Bcd;
          ack_nxt     = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
          state_nxt   = S_IDLE;
        end else if (timer_q == TIM_W'(TIMEOUT-1)) begin
          ack_nxt         = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
          timeout_err_nxt = 1'b1;
          state_nxt       = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs; reset abandons any conversion in flight
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= PTR_W'(N_REQ-1);
      timer_q       <= '0;
      ack_q         <= '0;
      res_bcd_q     <= '0;
      timeout_err_q <= 1'b0;
      conv_start_q  <= 1'b0;
      conv_bin_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      grant_q       <= grant_nxt;
      rr_ptr_q      <= rr_ptr_nxt;
      timer_q       <= timer_nxt;
      ack_q         <= ack_nxt;
      res_bcd_q     <= res_bcd_nxt;
      timeout_err_q <= timeout_err_nxt;
      conv_start_q  <= conv_start_nxt;
      conv_bin_q    <= conv_bin_nxt;
      busy_q        <= busy_nxt;
    end
  end

  assign Ack         = ack_q;
  assign Res_Bcd     = res_bcd_q;
  assign Timeout_Err = timeout_err_q;
  assign Busy        = busy_q;
  assign Conv_Start  = conv_start_q;
  assign Conv_Bin    = conv_bin_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// tb/tb_bcd_convert_arbiter.sv - directed bench for bcd_convert_arbiter
module tb_bcd_convert_arbiter;

  logic        Clk;
  logic        Rst;
  logic [2:0]  Req;
  logic [59:0] Req_Bin;
  logic [2:0]  Ack;
  logic [27:0] Res_Bcd;
  logic        Timeout_Err;
  logic        Busy;
  logic        Conv_Start;
  logic [19:0] Conv_Bin;
  logic [27:0] Conv_Bcd;
  logic        Conv_Done;

  logic [19:0] bin0, bin1, bin2;
  logic        no_done;
  logic        m_active;
  logic [4:0]  m_cnt;
  logic [19:0] m_bin;
  int          total;
  int          bad;

  assign Req_Bin = {bin2, bin1, bin0};

  bcd_convert_arbiter #(.N_REQ(3), .BIN_W(20), .BCD_W(28), .TIMEOUT(40)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Req_Bin(Req_Bin), .Ack(Ack), .Res_Bcd(Res_Bcd),
    .Timeout_Err(Timeout_Err), .Busy(Busy), .Conv_Start(Conv_Start), .Conv_Bin(Conv_Bin),
    .Conv_Bcd(Conv_Bcd), .Conv_Done(Conv_Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [27:0] to_bcd(input logic [19:0] v);
    logic [27:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < 7; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Converter model: samples start, raises Done one cycle, 19 cycles later
  always @(posedge Clk) begin
    if (Rst) begin
      m_active  <= 1'b0;
      m_cnt     <= '0;
      m_bin     <= '0;
      Conv_Done <= 1'b0;
      Conv_Bcd  <= '0;
    end else begin
      Conv_Done <= 1'b0;
      if (m_active) begin
        if (m_cnt == 5'd18) begin
          m_active <= 1'b0;
          if (!no_done) begin
            Conv_Done <= 1'b1;
            Conv_Bcd  <= to_bcd(m_bin);
          end
        end else begin
          m_cnt <= m_cnt + 5'd1;
        end
      end else if (Conv_Start) begin
        m_active <= 1'b1;
        m_cnt    <= '0;
        m_bin    <= Conv_Bin;
      end
    end
  end

  task automatic wait_ack(input int limit, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < limit) begin
      @(posedge Clk); #1;
      i++;
      if (Ack !== 3'b000) n = i;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1; Req = '0; bin0 = '0; bin1 = '0; bin2 = '0;
    repeat (3) @(posedge Clk);
    #1;
    total++; if (Ack !== 3'b000) begin bad++; $display("FAIL reset_ack: got %b want 000", Ack); end
    total++; if (Res_Bcd !== 28'h0) begin bad++; $display("FAIL reset_res: got %h want 0", Res_Bcd); end
    total++; if (Timeout_Err !== 1'b0) begin bad++; $display("FAIL reset_terr: got %b want 0", Timeout_Err); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Conv_Start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", Conv_Start); end
    total++; if (Conv_Bin !== 20'h0) begin bad++; $display("FAIL reset_bin: got %h want 0", Conv_Bin); end
    Rst = 1'b0;
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_single;
    int n;
    bin0 = 20'd123456; Req = 3'b001;
    @(posedge Clk); #1;
    total++; if (Conv_Start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", Conv_Start); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", Busy); end
    total++; if (Conv_Bin !== 20'd123456) begin bad++; $display("FAIL single_bin: got %0d want 123456", Conv_Bin); end
    @(posedge Clk); #1;
    total++; if (Conv_Start !== 1'b0) begin bad++; $display("FAIL single_start_pulse: got %b want 0", Conv_Start); end
    wait_ack(60, n);
    total++; if (n !== 20) begin bad++; $display("FAIL single_latency: got %0d want 20 (21 after grant)", n); end
    total++; if (Ack !== 3'b001) begin bad++; $display("FAIL single_ack: got %b want 001", Ack); end
    total++; if (Res_Bcd !== 28'h0123456) begin bad++; $display("FAIL single_res: got %h want 0123456", Res_Bcd); end
    total++; if (Timeout_Err !== 1'b0) begin bad++; $display("FAIL single_terr: got %b want 0", Timeout_Err); end
    Req = 3'b000;
    @(posedge Clk); #1;
    total++; if (Ack !== 3'b000) begin bad++; $display("FAIL single_ack_clear: got %b want 000", Ack); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", Busy); end
  endtask

  task automatic test_boundaries;
    int n;
    bin1 = 20'd0; Req = 3'b010;
    wait_ack(60, n);
    total++; if (n !== 22) begin bad++; $display("FAIL zero_latency: got %0d want 22", n); end
    total++; if (Ack !== 3'b010) begin bad++; $display("FAIL zero_ack: got %b want 010", Ack); end
    total++; if (Res_Bcd !== 28'h0000000) begin bad++; $display("FAIL zero_res: got %h want 0000000", Res_Bcd); end
    Req = 3'b000;
    @(posedge Clk); #1;
    bin2 = 20'hFFFFF; Req = 3'b100;
    wait_ack(60, n);
    total++; if (Ack !== 3'b100) begin bad++; $display("FAIL max_ack: got %b want 100", Ack); end
    total++; if (Res_Bcd !== 28'h1048575) begin bad++; $display("FAIL max_res: got %h want 1048575", Res_Bcd); end
    total++; if (Timeout_Err !== 1'b0) begin bad++; $display("FAIL max_terr: got %b want 0", Timeout_Err); end
    Req = 3'b000;
    @(posedge Clk); #1;
  endtask

  task automatic test_fairness;
    int n;
    bin0 = 20'd500; bin2 = 20'd600; Req = 3'b101;
    @(posedge Clk); #1;
    total++; if (Conv_Bin !== 20'd500) begin bad++; $display("FAIL fair_wrap_bin: got %0d want 500", Conv_Bin); end
    bin1 = 20'd700; Req = 3'b111;
    wait_ack(60, n);
    total++; if (Ack !== 3'b001) begin bad++; $display("FAIL fair_ack0: got %b want 001", Ack); end
    total++; if (Res_Bcd !== 28'h0000500) begin bad++; $display("FAIL fair_res0: got %h want 0000500", Res_Bcd); end
    Req = 3'b110;
    wait_ack(60, n);
    total++; if (Ack !== 3'b010) begin bad++; $display("FAIL fair_ack1: got %b want 010", Ack); end
    total++; if (Res_Bcd !== 28'h0000700) begin bad++; $display("FAIL fair_res1: got %h want 0000700", Res_Bcd); end
    Req = 3'b100;
    wait_ack(60, n);
    total++; if (Ack !== 3'b100) begin bad++; $display("FAIL fair_ack2: got %b want 100", Ack); end
    total++; if (Res_Bcd !== 28'h0000600) begin bad++; $display("FAIL fair_res2: got %h want 0000600", Res_Bcd); end
    Req = 3'b000;
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    logic [2:0]  exp_ack [4];
    logic [27:0] exp_res [4];
    exp_ack = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_res = '{28'h11, 28'h22, 28'h33, 28'h11};
    bin0 = 20'd11; bin1 = 20'd22; bin2 = 20'd33; Req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, n);
      total++; if (n !== 22) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 22", k, n); end
      total++; if (Ack !== exp_ack[k]) begin bad++; $display("FAIL b2b_ack%0d: got %b want %b", k, Ack, exp_ack[k]); end
      total++; if (Res_Bcd !== exp_res[k]) begin bad++; $display("FAIL b2b_res%0d: got %h want %h", k, Res_Bcd, exp_res[k]); end
      if (k == 3) Req = 3'b000;
    end
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", Busy); end
  endtask

  task automatic test_watchdog;
    int n;
    no_done = 1'b1;
    bin0 = 20'd999; Req = 3'b001;
    wait_ack(80, n);
    total++; if (n !== 42) begin bad++; $display("FAIL wd_latency: got %0d want 42", n); end
    total++; if (Ack !== 3'b001) begin bad++; $display("FAIL wd_ack: got %b want 001", Ack); end
    total++; if (Timeout_Err !== 1'b1) begin bad++; $display("FAIL wd_terr: got %b want 1", Timeout_Err); end
    total++; if (Res_Bcd !== 28'h11) begin bad++; $display("FAIL wd_res_kept: got %h want 0000011", Res_Bcd); end
    Req = 3'b000;
    @(posedge Clk); #1;
    total++; if (Timeout_Err !== 1'b0) begin bad++; $display("FAIL wd_terr_clear: got %b want 0", Timeout_Err); end
    total++; if (Ack !== 3'b000) begin bad++; $display("FAIL wd_ack_clear: got %b want 000", Ack); end
    no_done = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    bin0 = 20'd31; Req = 3'b001;
    repeat (12) @(posedge Clk);
    #1;
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", Busy); end
    Rst = 1'b1; Req = 3'b000;
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", Busy); end
    total++; if (Conv_Bin !== 20'h0) begin bad++; $display("FAIL mid_rst_bin: got %h want 0", Conv_Bin); end
    total++; if (Res_Bcd !== 28'h0) begin bad++; $display("FAIL mid_rst_res: got %h want 0", Res_Bcd); end
    total++; if (Ack !== 3'b000) begin bad++; $display("FAIL mid_rst_ack: got %b want 000", Ack); end
    total++; if (Conv_Start !== 1'b0) begin bad++; $display("FAIL mid_rst_start: got %b want 0", Conv_Start); end
    Rst = 1'b0;
    bin0 = 20'd4321; bin1 = 20'd777; Req = 3'b011;
    wait_ack(60, n);
    total++; if (n !== 22) begin bad++; $display("FAIL post_rst_latency: got %0d want 22", n); end
    total++; if (Ack !== 3'b001) begin bad++; $display("FAIL post_rst_prio: got %b want 001", Ack); end
    total++; if (Res_Bcd !== 28'h0004321) begin bad++; $display("FAIL post_rst_res0: got %h want 0004321", Res_Bcd); end
    Req = 3'b010;
    wait_ack(60, n);
    total++; if (Ack !== 3'b010) begin bad++; $display("FAIL post_rst_ack1: got %b want 010", Ack); end
    total++; if (Res_Bcd !== 28'h0000777) begin bad++; $display("FAIL post_rst_res1: got %h want 0000777", Res_Bcd); end
    Req = 3'b000;
    @(posedge Clk); #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    no_done = 1'b0;
    Rst = 1'b1;
    Req = '0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    test_reset;
    test_single;
    test_boundaries;
    test_fairness;
    test_back_to_back;
    test_watchdog;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
